sweep_vector_sequencer: RTL
===========================

Name: sweep_vector_sequencer

Overview:
- Controller that sequences an exhaustive input sweep into a single-output DUT under trojan-detection test.
- Drives every vector 0 .. 2^N_WIDTH-1 in ascending order and waits a programmable settle time per vector.
- Samples the DUT output bit and hands each (vector, bit) record to a downstream logger over a valid/ready handshake.
- Accumulates a 16-bit MISR signature and a ones count for fast golden-vs-suspect comparison.

Parameters:
- N_WIDTH, 5, DUT input vector width; sweep length is 2^N_WIDTH.
- SETTLE_CYCLES, 1, cycles each vector is held before sampling; legal range >= 1.
- SIG_POLY, 16'h1021, MISR feedback polynomial.

Ports:
- CK  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  input  1  synchronous cancel of an in-progress sweep.
- vec_out  output  N_WIDTH  vector driven to DUT inputs.
- dut_out  input  1  DUT output bit being observed.
- rec_valid  output  1  record available.
- rec_ready  input  1  logger accepts record.
- rec_vec  output  N_WIDTH  vector of current record.
- rec_bit  output  1  sampled DUT bit of current record.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when the sweep completes normally.
- ones_count  output  N_WIDTH+1  number of sampled 1s in the current/last sweep.
- signature  output  16  MISR over sampled bits.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - vec_out, rec_vec, rec_bit, rec_valid, busy, done, ones_count and signature all go to 0.
- States: IDLE, SETTLE, SAMPLE, EMIT, DONE.
- IDLE:
  - start=1 and abort=0: vec_out<=0, ones_count<=0, signature<=0, settle counter<=SETTLE_CYCLES, go to SETTLE.
  - start and abort both high: stay in IDLE.
- SETTLE:
  - Counter decrements each cycle, so the state lasts exactly SETTLE_CYCLES cycles.
  - Then go to SAMPLE.
- SAMPLE (exactly 1 cycle):
  - rec_vec<=vec_out, rec_bit<=dut_out, ones_count<=ones_count+dut_out.
  - signature<=({sig[14:0],1'b0} ^ (sig[15] ? SIG_POLY : 0)) ^ {15'b0,dut_out}.
  - Go to EMIT.
- EMIT:
  - rec_valid=1; rec_vec and rec_bit are held stable until rec_valid && rec_ready.
  - On handshake with vec_out == all ones: go to DONE.
  - On handshake otherwise: vec_out<=vec_out+1, reload settle counter, go to SETTLE.
  - rec_valid drops in the cycle after the handshake.
- DONE (1 cycle):
  - done=1, then go to IDLE.
  - ones_count and signature hold until the next accepted start.
- Timing:
  - Per-vector cost is SETTLE_CYCLES+2 cycles with rec_ready tied high.
  - Full sweep is 2^N_WIDTH*(SETTLE_CYCLES+2) cycles from the start cycle to DONE entry.
- vec_out changes only on entry to SETTLE, so the DUT input never changes while a record is pending.
- abort=1 in SETTLE, SAMPLE or EMIT:
  - Next state is IDLE; vec_out<=0, rec_valid<=0.
  - done is not pulsed; ones_count and signature freeze at their partial values.
  - abort in IDLE or DONE is ignored; DONE still pulses.
- start while busy is ignored; no restart and no queueing.
- ones_count cannot overflow: its maximum is 2^N_WIDTH, which fits in N_WIDTH+1 bits.
- Reset asserted mid-sweep overrides everything immediately; no record is emitted after it.

Test Plan:
- dut_out=0, rec_ready=1, SETTLE_CYCLES=1, pulse start -> 32 records with rec_vec 0..31 in order, all rec_bit=0. done pulses exactly 96 cycles after start; ones_count=0, signature=16'h0000.
- dut_out tied to vec_out[0] -> records alternate 0,1,…; ones_count=16 at done.
- dut_out=1 only when vec_out==31 -> final signature=16'h0001, ones_count=1.
- rec_ready held low 5 cycles while rec_vec=3 -> rec_valid stays 1; rec_vec=3 and vec_out=3 stay stable; sweep resumes with vector 4 after the handshake; done is delayed by exactly 5 cycles.
- abort asserted in SETTLE of vector 10 -> busy=0 the next cycle, vec_out=0, no done pulse, ones_count frozen. A subsequent start restarts at vector 0 with the counters cleared.
- reset driven to 0 during EMIT of vector 7 -> all outputs 0 asynchronously (before the next CK edge); start ignored while reset=0; a start after release gives a clean full sweep.

Source files
------------

// File: rtl/sweep_vector_sequencer.sv
// sweep_vector_sequencer
//   Drives every input vector 0 .. 2^N_WIDTH-1 into a single-output DUT in
//   ascending order, holds each vector for SETTLE_CYCLES cycles, samples the
//   DUT output and offers a (vector, bit) record to a logger over valid/ready.
//   A 16-bit MISR signature and a ones count summarise the sweep.
//
// Ports
//   CK          clock, rising edge
//   reset       asynchronous active-low reset
//   start       one-cycle sweep request, honoured only when idle
//   abort       synchronous cancel of an in-progress sweep
//   vec_out     vector applied to the DUT inputs
//   dut_out     observed DUT output bit
//   rec_valid   record available
//   rec_ready   logger accepts record
//   rec_vec     vector of the current record
//   rec_bit     sampled DUT bit of the current record
//   busy        high whenever not idle
//   done        one-cycle pulse on normal sweep completion
//   ones_count  number of sampled ones in the current/last sweep
//   signature   MISR over the sampled bits
module sweep_vector_sequencer #(
    parameter int          N_WIDTH       = 5,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] SIG_POLY      = 16'h1021
) (
    input  logic               CK,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    output logic [N_WIDTH-1:0] vec_out,
    input  logic               dut_out,
    output logic               rec_valid,
    input  logic               rec_ready,
    output logic [N_WIDTH-1:0] rec_vec,
    output logic               rec_bit,
    output logic               busy,
    output logic               done,
    output logic [N_WIDTH:0]   ones_count,
    output logic [15:0]        signature
);

    localparam int CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_EMIT,
        S_DONE
    } state_e;

    state_e             state_q, state_d;
    logic [N_WIDTH-1:0] vec_q, vec_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_WIDTH-1:0] rec_vec_q, rec_vec_d;
    logic               rec_bit_q, rec_bit_d;
    logic [N_WIDTH:0]   ones_q, ones_d;
    logic [15:0]        sig_q, sig_d;
    logic [15:0]        sig_next;

    // One MISR step: shift, fold in the polynomial on carry-out, xor the new bit.
    always_comb begin
        sig_next = {sig_q[14:0], 1'b0} ^ (sig_q[15] ? SIG_POLY : 16'h0000)
                   ^ {15'b0, dut_out};
    end

    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        rec_vec_d = rec_vec_q;
        rec_bit_d = rec_bit_q;
        ones_d    = ones_q;
        sig_d     = sig_q;

        unique case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    vec_d   = '0;
                    ones_d  = '0;
                    sig_d   = '0;
                    cnt_d   = SETTLE_LOAD;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (abort) begin
                    vec_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_SAMPLE;
                    end
                end
            end
            S_SAMPLE: begin
                // Abort wins over the sample so the counters freeze at their
                // partial values.
                if (abort) begin
                    vec_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    rec_vec_d = vec_q;
                    rec_bit_d = dut_out;
                    ones_d    = ones_q + (N_WIDTH + 1)'(dut_out);
                    sig_d     = sig_next;
                    state_d   = S_EMIT;
                end
            end
            S_EMIT: begin
                if (abort) begin
                    vec_d   = '0;
                    state_d = S_IDLE;
                end else if (rec_ready) begin
                    if (vec_q == '1) begin
                        state_d = S_DONE;
                    end else begin
                        vec_d   = vec_q + 1'b1;
                        cnt_d   = SETTLE_LOAD;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CK or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            vec_q     <= '0;
            cnt_q     <= '0;
            rec_vec_q <= '0;
            rec_bit_q <= 1'b0;
            ones_q    <= '0;
            sig_q     <= '0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            rec_vec_q <= rec_vec_d;
            rec_bit_q <= rec_bit_d;
            ones_q    <= ones_d;
            sig_q     <= sig_d;
        end
    end

    // Status outputs decode the state register directly, so an asynchronous
    // reset clears them without waiting for a clock edge.
    always_comb begin
        vec_out    = vec_q;
        rec_vec    = rec_vec_q;
        rec_bit    = rec_bit_q;
        rec_valid  = (state_q == S_EMIT);
        busy       = (state_q != S_IDLE);
        done       = (state_q == S_DONE);
        ones_count = ones_q;
        signature  = sig_q;
    end

endmodule
